dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Memory-side responder for the MEM stage data-memory port. It accepts one
//   load/store request at a time through a valid/ready handshake and models a
//   fixed access latency. It returns a single-cycle response pulse carrying
//   load data or a store acknowledge.
//   It sits between the MEM stage request port and a word-addressed storage
//   array. The pipeline stalls on !req_ready and stalls while waiting for resp_valid.
// PARAMETERS
//   DEPTH    256  words of storage; power of two; AW = $clog2(DEPTH)
//   LATENCY  2    edges from acceptance to response; legal range 1..15
//   ADDR_LSB 2    byte-offset bits dropped from req_addr (byte address -> word index)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   req_valid  in   1      request present
//   req_ready  out  1      responder can accept (high only in IDLE)
//   req_we     in   1      1 = store, 0 = load
//   req_addr   in   `WORD  byte address (the ALU result)
//   req_wdata  in   `WORD  store data
//   resp_valid out  1      one-cycle pulse: access complete
//   resp_rdata out  `WORD  load data; 0 for stores; held until the next response
//   resp_err   out  1      misaligned-access flag, valid with resp_valid
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0,
//     resp_err=0, count=0, latched request regs=0, storage array zeroed.
//   - States: IDLE, BUSY. IDLE->BUSY on req_valid&&req_ready. BUSY->IDLE when count==0.
//   - Acceptance edge E: latch we/addr/wdata; count<=LATENCY-1.
//   - In BUSY each edge: if count!=0, count<=count-1.
//     Else perform the access, set resp_valid<=1, return to IDLE.
//   - resp_valid is high in the cycle after edge E+LATENCY, for exactly one cycle.
//   - Back-to-back: req_ready=1 in the cycle resp_valid=1, so a new request can be
//     accepted there. Minimum spacing between requests is LATENCY+1 cycles.
//   - Word index = addr[ADDR_LSB+AW-1:ADDR_LSB]. Upper bits are ignored (alias/wrap).
//   - Store: array[idx]<=wdata on the completion edge; resp_rdata<=0.
//   - Load: resp_rdata<=array[idx] on the completion edge.
//   - Read-after-write to the same index in consecutive transactions returns the new data.
//   - req_* inputs are ignored while BUSY. Changing them mid-transaction has no effect.
//   - Reset mid-transaction aborts it: no write is performed and no response is issued.
//   - No response backpressure: the initiator must sample resp_* while resp_valid is high.
// CONFIGURATION
//   DMEM_ALIGN_CHECK_EN defined:
//     A request with addr[ADDR_LSB-1:0]!=0 completes with normal latency and
//     resp_err=1, resp_rdata=0, and no array write.
//   DMEM_ALIGN_CHECK_EN undefined:
//     The low address bits are silently ignored and resp_err is tied to 0.
// STRUCTURE
//   - Shared constants in constants.v: `WORD (existing), `DMEM_IDLE=1'b0, `DMEM_BUSY=1'b1.
//   - One sub-module, dmem_array:
//     DEPTH x `WORD storage, synchronous write, combinational read, async zero on rst.
//   - FSM, latency counter, request latches and response regs stay in dmem_responder.
// TESTING
//   1. Reset, then load addr 0x10 (LATENCY=2):
//      req_ready=1; resp_valid pulses 2 edges after acceptance with rdata=0.
//   2. Store 0xDEADBEEF @0x20, then load @0x20:
//      store resp_valid with rdata=0; load returns 0xDEADBEEF.
//   3. Back-to-back: hold req_valid high across a store @0x4 (0x11) and a load @0x4:
//      the second request is accepted in the store's resp_valid cycle;
//      the load returns 0x11 LATENCY+1 cycles later.
//   4. Aliasing (DEPTH=256): store 0x55 @0x400, then load @0x0 -> 0x55.
//   5. Assert rst one edge after accepting a store 0x77 @0x8:
//      no resp_valid is issued; a later load @0x8 returns 0.
//   6. Load @0x22:
//      with DMEM_ALIGN_CHECK_EN, resp_err=1 and rdata=0;
//      without it, resp_err=0 and the data of word 0x20 is returned.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Word width and FSM state encoding used by dmem_responder and dmem_array.
package dmem_responder_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    DMEM_IDLE = 1'b0,
    DMEM_BUSY = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: synchronous write, combinational read,
// whole array cleared by asynchronous reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one request at a time, fixed latency.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses via resp_err.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int LATENCY  = 2,
  parameter int ADDR_LSB = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  req_valid,
  output logic  req_ready,
  input  logic  req_we,
  input  word_t req_addr,
  input  word_t req_wdata,
  output logic  resp_valid,
  output word_t resp_rdata,
  output logic  resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  dmem_state_e   state;
  logic [3:0]    count;
  logic          lat_we;
  word_t         lat_addr;
  word_t         lat_wdata;
  logic [AW-1:0] idx;
  logic          misaligned;
  logic          done;
  logic          arr_we;
  word_t         arr_rdata;
  logic          unused_addr_bits;

  // Upper bits alias onto the array; low bits only matter for alignment.
  assign idx = lat_addr[ADDR_LSB+AW-1:ADDR_LSB];
  assign unused_addr_bits = ^{lat_addr[WORD_W-1:ADDR_LSB+AW],
                              lat_addr[ADDR_LSB-1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = |lat_addr[ADDR_LSB-1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign done      = (state == DMEM_BUSY) && (count == 4'd0);
  assign arr_we    = done && lat_we && !misaligned;
  assign req_ready = (state == DMEM_IDLE);

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .addr  (idx),
    .wdata (lat_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DMEM_IDLE;
      count      <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
      resp_err   <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        DMEM_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            count     <= CNT_INIT;
            state     <= DMEM_BUSY;
          end
        end
        DMEM_BUSY: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= (lat_we || misaligned) ? '0 : arr_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
            resp_err   <= misaligned;
`endif
            state      <= DMEM_IDLE;
          end
        end
        default: state <= DMEM_IDLE;
      endcase
    end
  end

`ifndef DMEM_ALIGN_CHECK_EN
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency, RAW, back-to-back,
// aliasing, mid-transaction reset and alignment handling.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int LAT = 2;

  logic  clk = 1'b0;
  logic  rst;
  logic  req_valid;
  logic  req_ready;
  logic  req_we;
  word_t req_addr;
  word_t req_wdata;
  logic  resp_valid;
  word_t resp_rdata;
  logic  resp_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH    (256),
    .LATENCY  (LAT),
    .ADDR_LSB (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a request and return just after its acceptance edge.
  task automatic issue(input logic we, input word_t addr, input word_t wd);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_wait", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Count edges until resp_valid, then check payload and optionally pulse width.
  task automatic wait_resp(input string tag, input int exp_lat,
                           input word_t exp_d, input logic exp_e,
                           input logic chk_pulse);
    int n;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_rdata"}, resp_rdata, exp_d);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_e));
    if (chk_pulse) begin
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: load from cleared memory
    issue(1'b0, 32'h10, '0);
    check("t1_busy", 32'(req_ready), 32'd0);
    wait_resp("t1", LAT, 32'h0, 1'b0, 1'b1);

    // 2: store then load same word
    issue(1'b1, 32'h20, 32'hDEADBEEF);
    wait_resp("t2_st", LAT, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h20, '0);
    wait_resp("t2_ld", LAT, 32'hDEADBEEF, 1'b0, 1'b1);

    // 3: back-to-back with req_valid held; inputs change mid-transaction
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h4;
    req_wdata = 32'h11;
    @(posedge clk); #1;
    req_we    = 1'b0;
    req_wdata = 32'hFFFF_FFFF;
    wait_resp("t3_st", LAT, 32'h0, 1'b0, 1'b0);
    check("t3_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    // load response lands LAT+1 edges after the store response
    wait_resp("t3_ld", LAT, 32'h11, 1'b0, 1'b1);

    // 4: aliasing on upper address bits
    issue(1'b1, 32'h400, 32'h55);
    wait_resp("t4_st", LAT, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h0, '0);
    wait_resp("t4_ld", LAT, 32'h55, 1'b0, 1'b1);

    // 5: reset one edge after accepting a store
    issue(1'b1, 32'h8, 32'h77);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(resp_valid), 32'd0);
    check("t5_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      seen = seen | resp_valid;
    end
    check("t5_no_resp", 32'(seen), 32'd0);
    issue(1'b0, 32'h8, '0);
    wait_resp("t5_ld", LAT, 32'h0, 1'b0, 1'b1);

    // 6: misaligned load and store
    issue(1'b1, 32'h20, 32'hCAFEF00D);
    wait_resp("t6_st", LAT, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h22, '0);
`ifdef DMEM_ALIGN_CHECK_EN
    wait_resp("t6_mis_ld", LAT, 32'h0, 1'b1, 1'b1);
`else
    wait_resp("t6_mis_ld", LAT, 32'hCAFEF00D, 1'b0, 1'b1);
`endif
    issue(1'b1, 32'h21, 32'h99);
`ifdef DMEM_ALIGN_CHECK_EN
    wait_resp("t6_mis_st", LAT, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 32'h20, '0);
    wait_resp("t6_ld", LAT, 32'hCAFEF00D, 1'b0, 1'b1);
`else
    wait_resp("t6_mis_st", LAT, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h20, '0);
    wait_resp("t6_ld", LAT, 32'h99, 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
